fft_reorder_ctrl: RTL and testbench

FFT_REORDER_CTRL -- requirements
Module: fft_reorder_ctrl

---
 rtl/fft_reorder_ctrl.sv | 132 +++++++++++++
 tb/tb_fft_reorder_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_ctrl.sv
// Address/handshake controller for a single-memory FFT output reorder buffer:
// one frame is written in natural order, then read back bit-reversed or in natural order.
module fft_reorder_ctrl #(
    parameter int log2N = 6,
    parameter int N     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bitrev_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [log2N-1:0] out_idx,
    output logic             mem_we,
    output logic [log2N-1:0] mem_addra,
    output logic [log2N-1:0] mem_addrb,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    localparam logic [log2N-1:0] LAST = log2N'(N - 1);
    localparam logic [log2N-1:0] ONE  = log2N'(1);

    state_t           state_q, state_d;
    logic [log2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [log2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic [log2N-1:0] rd_next;

    function automatic logic [log2N-1:0] bitrev(input logic [log2N-1:0] v);
        logic [log2N-1:0] r;
        for (int i = 0; i < log2N; i++) r[i] = v[log2N-1-i];
        return r;
    endfunction

    // The read address looks one beat ahead so the synchronous memory has the
    // next sample ready exactly when the current one is accepted.
    assign accept  = out_valid_q & out_ready;
    assign rd_next = accept ? rd_cnt_q + ONE : rd_cnt_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addra    = '0;
        mem_addrb    = '0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = FILL;
                    mode_d   = bitrev_en;
                    wr_cnt_d = '0;
                end
            end
            FILL: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addra = wr_cnt_q;
                if (in_valid) begin
                    wr_cnt_d = wr_cnt_q + ONE;
                    if (wr_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                mem_addrb = mode_q ? bitrev(rd_next) : rd_next;
                if (!out_valid_q) out_valid_d = 1'b1;
                if (accept) begin
                    rd_cnt_d = rd_next;
                    if (rd_cnt_q == LAST) begin
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        rd_cnt_d     = '0;
                        if (en) begin
                            state_d = FILL;
                            mode_d  = bitrev_en;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset is active-high on this block despite the rst_n name.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_n) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_valid_q ? rd_cnt_q : '0;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Directed bench for fft_reorder_ctrl with a behavioural synchronous sample memory.
module tb_fft_reorder_ctrl;

    localparam int LOG2N = 6;
    localparam int N     = 64;

    logic             clk = 1'b0;
    logic             rst_n, en, bitrev_en, in_valid, in_ready;
    logic             out_ready, out_valid, mem_we, frame_done;
    logic [LOG2N-1:0] out_idx, mem_addra, mem_addrb;
    logic [7:0]       wdata, rd_data;
    logic [7:0]       mem [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_reorder_ctrl #(.log2N(LOG2N), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bitrev_en  (bitrev_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .mem_we     (mem_we),
        .mem_addra  (mem_addra),
        .mem_addrb  (mem_addrb),
        .frame_done (frame_done)
    );

    // Sample memory: synchronous write and registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addra] <= wdata;
        rd_data <= mem[mem_addrb];
    end

    typedef struct {
        logic       en;
        logic       br;
        logic       iv;
        logic [7:0] wd;
        logic       exp_ir;
        logic       exp_we;
        logic [5:0] exp_a;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] brev(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_addra"}, mem_addra, 0);
        check({tag, "_addrb"}, mem_addrb, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic go_fill(input logic br);
        en = 1'b1; bitrev_en = br; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_mem_we", mem_we, 0);
        tick();
    endtask

    task automatic fill(input int from, input logic [7:0] base, input bit gaps, input logic en_v);
        for (int i = from; i < N; i++) begin
            if (gaps && (i % 7 == 3)) begin
                en = en_v; in_valid = 1'b0; wdata = 8'hEE;
                #1;
                check("fill_gap_we", mem_we, 0);
                check("fill_gap_addra", mem_addra, i);
                tick();
            end
            en = en_v; bitrev_en = i[0]; in_valid = 1'b1; wdata = 8'(base + 8'(i));
            #1;
            check("fill_in_ready", in_ready, 1);
            check("fill_we", mem_we, 1);
            check("fill_addra", mem_addra, i);
            check("fill_out_valid", out_valid, 0);
            tick();
        end
    endtask

    task automatic drain(input logic [7:0] base, input logic mode, input bit rand_ready,
                         input logic en_v, input logic next_br, input logic exp_fill);
        int         k     = 0;
        bit         first = 1'b1;
        logic [7:0] exp_d;
        logic       acc;
        for (int c = 0; c < 1000 && k < N; c++) begin
            en = en_v; bitrev_en = next_br; in_valid = 1'b1; wdata = 8'($urandom);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("drain_in_ready", in_ready, 0);
            check("drain_we", mem_we, 0);
            check("drain_addra", mem_addra, 0);
            check("drain_frame_done", frame_done, 0);
            if (first) begin
                check("drain_first_out_valid", out_valid, 0);
            end else begin
                check("drain_out_valid", out_valid, 1);
                check("drain_out_idx", out_idx, k);
                exp_d = 8'(base + (mode ? 8'(brev(6'(k))) : 8'(k)));
                check("drain_data", rd_data, exp_d);
            end
            acc = !first && out_ready;
            tick();
            first = 1'b0;
            if (acc) k++;
        end
        if (k != N) check("drain_timeout_count", k, N);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("end_frame_done", frame_done, 1);
        check("end_out_valid", out_valid, 0);
        check("end_out_idx", out_idx, 0);
        check("end_addrb", mem_addrb, 0);
        check("end_next_fill", in_ready, exp_fill);
        tick();
        check("end_frame_done_pulse", frame_done, 0);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; bitrev_en = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; wdata = '0;
        #2;
        check_reset_outs("reset");
        #10 rst_n = 1'b0;
        tick();

        // IDLE ignores in_valid; mode latched at FILL entry; writes only on in_valid beats.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 6'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 6'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 6'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 6'd1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 6'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 6'd2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 6'd2};
        for (int v = 0; v < 7; v++) begin
            en = tbl[v].en; bitrev_en = tbl[v].br; in_valid = tbl[v].iv; wdata = tbl[v].wd;
            #1;
            check($sformatf("vec%0d_in_ready", v), in_ready, tbl[v].exp_ir);
            check($sformatf("vec%0d_mem_we", v), mem_we, tbl[v].exp_we);
            check($sformatf("vec%0d_addra", v), mem_addra, tbl[v].exp_a);
            check($sformatf("vec%0d_out_valid", v), out_valid, 0);
            check($sformatf("vec%0d_addrb", v), mem_addrb, 0);
            tick();
        end

        // Frame A: bit-reversed, en low throughout, ends in IDLE.
        fill(3, 8'h00, 1'b0, 1'b0);
        drain(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Frame B natural with gaps and random out_ready, then C with en dropped.
        go_fill(1'b0);
        fill(0, 8'h80, 1'b1, 1'b1);
        drain(8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        fill(0, 8'h00, 1'b0, 1'b0);
        drain(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Three back-to-back frames with alternating modes.
        go_fill(1'b1);
        fill(0, 8'h40, 1'b0, 1'b1);
        drain(8'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        fill(0, 8'h10, 1'b1, 1'b1);
        drain(8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        fill(0, 8'h33, 1'b0, 1'b1);
        drain(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset at write beat 30 discards the frame.
        go_fill(1'b0);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; wdata = 8'(8'hA0 + 8'(i));
            tick();
        end
        in_valid = 1'b1; wdata = 8'hBE;
        #1;
        check("pre_reset_addra", mem_addra, 30);
        #1 rst_n = 1'b1;
        #1;
        check_reset_outs("midreset");
        tick();
        check_reset_outs("heldreset");
        #1 rst_n = 1'b0; en = 1'b0; in_valid = 1'b0;
        tick();
        go_fill(1'b1);
        fill(0, 8'hC0, 1'b0, 1'b0);
        drain(8'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
